// File: rtl/dmem_wait_ctrl.sv
// Fixed-latency data-memory responder for the MEM stage: stalls the pipeline for LATENCY cycles per access.
// Optional misaligned-access detection is enabled by defining DMEM_ERR_EN (adds the addr_err port).
module dmem_wait_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memread_mem,
    input  logic              memwrite_mem,
    input  logic [31:0]       addr_mem,
    input  logic [DATA_W-1:0] wdata_mem,
    output logic [DATA_W-1:0] rdata_mem,
    output logic              mem_stall
`ifdef DMEM_ERR_EN
    ,
    output logic              addr_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam int           DEPTH    = 1 << ADDR_W;
    localparam logic [3:0]   CNT_LOAD = 4'(LATENCY - 1);
    localparam logic         LAT_ONE  = (LATENCY == 1);

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic [DATA_W-1:0]   r_mem [0:DEPTH-1];
    logic [DATA_W-1:0]   r_rdata;

    logic                w_req;
    logic                w_commit;
    logic                w_misalign;
    logic                w_we;
    logic [ADDR_W-1:0]   w_idx;
    logic                w_unused_addr;

    assign w_req = memread_mem | memwrite_mem;
    assign w_idx = addr_mem[ADDR_W+1:2];

    // Upper address bits wrap the array; they are intentionally ignored.
    assign w_unused_addr = ^{addr_mem[31:ADDR_W+2], addr_mem[1:0]};

`ifdef DMEM_ERR_EN
    assign w_misalign = |addr_mem[1:0];
`else
    assign w_misalign = 1'b0;
`endif

    // The edge that enters DONE is the single commit point of an access.
    assign w_commit = ~rst & (((r_state == S_IDLE) & w_req & LAT_ONE) |
                              ((r_state == S_WAIT) & (r_cnt == 4'd1)));
    assign w_we     = w_commit & memwrite_mem & ~w_misalign;

    assign mem_stall = ~rst & (((r_state == S_IDLE) & w_req) | (r_state == S_WAIT));
    assign rdata_mem = r_rdata;

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_idx] <= wdata_mem;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= '0;
        end else begin
            // Read-before-write: a combined read+write returns the old word.
            if (w_commit) begin
                r_rdata <= w_misalign ? '0 : r_mem[w_idx];
            end
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (LAT_ONE) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= CNT_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd1) begin
                        r_state <= S_DONE;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    // A request still present here belongs to the finished instruction.
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_ERR_EN
    logic r_addr_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= w_commit & w_misalign;
        end
    end

    assign addr_err = r_addr_err;
`endif

endmodule
